// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller feeding the stack-machine ALU from the data stack:
// pops operands, strobes the ALU operand/overflow/compare registers, writes results back.
module alu_op_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  OP_VALID,
  output logic                  OP_READY,
  input  logic [3:0]            OP_CODE,
  input  logic [DATA_WIDTH-1:0] PUSH_DATA,
  output logic                  DONE,
  output logic                  ERR_UNDERFLOW,
  output logic                  ERR_FULL,
  output logic [ADDR_WIDTH-1:0] TOS,
  output logic [ADDR_WIDTH-1:0] STACK_ADDR,
  input  logic [DATA_WIDTH-1:0] STACK_RD_DATA,
  output logic                  STACK_WR_EN,
  output logic [DATA_WIDTH-1:0] STACK_WR_DATA,
  output logic [DATA_WIDTH-1:0] ALU_OPERAND,
  output logic                  CTRL_REG_OP1,
  output logic                  CTRL_REG_OP2,
  output logic                  CTRL_REG_OVERFLOW,
  output logic                  CTRL_STACK_COMP,
  output logic [3:0]            SEL_ULA,
  output logic [ADDR_WIDTH-1:0] COMP_ADDR,
  input  logic [DATA_WIDTH-1:0] ULA_RESULT
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_LD_A,
    ST_LD_B,
    ST_EXEC,
    ST_WR_PUSH,
    ST_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] TOS_MAX = '1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_op;
  logic [DATA_WIDTH-1:0] r_push_data;
  logic [ADDR_WIDTH-1:0] r_tos;
  logic [ADDR_WIDTH-1:0] w_tos_nxt;
  logic                  r_err_uf;
  logic                  r_err_full;
  logic                  w_set_uf;
  logic                  w_set_full;
  logic                  w_xfer;
  logic                  w_op_push;
  logic                  w_op_unary;
  logic                  w_op_bin;
  logic                  w_op_cmp;

  function automatic logic [ADDR_WIDTH-1:0] req_entries(input logic [3:0] op);
    if (op == 4'hF)      return '0;
    else if (op == 4'h8) return ADDR_WIDTH'(1);
    else                 return ADDR_WIDTH'(2);
  endfunction

  assign w_xfer     = OP_VALID && OP_READY;
  assign w_op_push  = (r_op == 4'hF);
  assign w_op_unary = (r_op == 4'h8);
  assign w_op_bin   = !r_op[3];
  assign w_op_cmp   = r_op[3] && !w_op_unary && !w_op_push;

  always_comb begin
    w_state_nxt = r_state;
    w_tos_nxt   = r_tos;
    w_set_uf    = 1'b0;
    w_set_full  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          if (r_tos < req_entries(OP_CODE)) begin
            w_set_uf    = 1'b1;
            w_state_nxt = ST_DONE;
          end else if (OP_CODE == 4'hF && r_tos == TOS_MAX) begin
            w_set_full  = 1'b1;
            w_state_nxt = ST_DONE;
          end else if (OP_CODE == 4'hF) begin
            w_state_nxt = ST_WR_PUSH;
          end else begin
            w_state_nxt = ST_RD_A;
          end
        end
      end
      ST_RD_A:  w_state_nxt = ST_LD_A;
      ST_LD_A:  w_state_nxt = w_op_unary ? ST_EXEC : ST_LD_B;
      ST_LD_B:  w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (w_op_bin)      w_tos_nxt = r_tos - ADDR_WIDTH'(1);
        else if (w_op_cmp) w_tos_nxt = r_tos - ADDR_WIDTH'(2);
        w_state_nxt = ST_DONE;
      end
      ST_WR_PUSH: begin
        w_tos_nxt   = r_tos + ADDR_WIDTH'(1);
        w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are gated by rst so an op caught mid-flight never writes or strobes.
  always_comb begin
    OP_READY          = 1'b0;
    DONE              = 1'b0;
    STACK_ADDR        = '0;
    STACK_WR_EN       = 1'b0;
    STACK_WR_DATA     = '0;
    ALU_OPERAND       = '0;
    CTRL_REG_OP1      = 1'b0;
    CTRL_REG_OP2      = 1'b0;
    CTRL_REG_OVERFLOW = 1'b0;
    CTRL_STACK_COMP   = 1'b0;
    COMP_ADDR         = r_tos;
    if (!rst) begin
      case (r_state)
        ST_IDLE: OP_READY = 1'b1;
        ST_RD_A: STACK_ADDR = r_tos - ADDR_WIDTH'(1);
        ST_LD_A: begin
          ALU_OPERAND  = STACK_RD_DATA;
          CTRL_REG_OP1 = 1'b1;
          if (!w_op_unary) STACK_ADDR = r_tos - ADDR_WIDTH'(2);
        end
        ST_LD_B: begin
          ALU_OPERAND  = STACK_RD_DATA;
          CTRL_REG_OP2 = 1'b1;
        end
        ST_EXEC: begin
          if (w_op_bin) begin
            STACK_WR_EN       = 1'b1;
            STACK_ADDR        = r_tos - ADDR_WIDTH'(2);
            STACK_WR_DATA     = ULA_RESULT;
            CTRL_REG_OVERFLOW = 1'b1;
          end else if (w_op_unary) begin
            STACK_WR_EN   = 1'b1;
            STACK_ADDR    = r_tos - ADDR_WIDTH'(1);
            STACK_WR_DATA = ULA_RESULT;
          end else begin
            CTRL_STACK_COMP = 1'b1;
            COMP_ADDR       = r_tos - ADDR_WIDTH'(2);
          end
        end
        ST_WR_PUSH: begin
          STACK_WR_EN   = 1'b1;
          STACK_ADDR    = r_tos;
          STACK_WR_DATA = r_push_data;
        end
        ST_DONE: DONE = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tos       <= '0;
      r_op        <= '0;
      r_push_data <= '0;
      r_err_uf    <= 1'b0;
      r_err_full  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tos   <= w_tos_nxt;
      if (w_xfer) begin
        r_op        <= OP_CODE;
        r_push_data <= PUSH_DATA;
      end
      if (w_set_uf)   r_err_uf   <= 1'b1;
      if (w_set_full) r_err_full <= 1'b1;
    end
  end

  assign TOS           = r_tos;
  assign SEL_ULA       = r_op;
  assign ERR_UNDERFLOW = r_err_uf;
  assign ERR_FULL      = r_err_full;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: stack memory and ALU environment, an abstract
// per-operation stack model, a per-cycle compare process and literal spot checks.
module tb_alu_op_sequencer;

  localparam int DW  = 8;
  localparam int AW  = 2;
  localparam int CAP = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          OP_VALID;
  logic          OP_READY;
  logic [3:0]    OP_CODE;
  logic [DW-1:0] PUSH_DATA;
  logic          DONE;
  logic          ERR_UNDERFLOW;
  logic          ERR_FULL;
  logic [AW-1:0] TOS;
  logic [AW-1:0] STACK_ADDR;
  logic [DW-1:0] STACK_RD_DATA;
  logic          STACK_WR_EN;
  logic [DW-1:0] STACK_WR_DATA;
  logic [DW-1:0] ALU_OPERAND;
  logic          CTRL_REG_OP1;
  logic          CTRL_REG_OP2;
  logic          CTRL_REG_OVERFLOW;
  logic          CTRL_STACK_COMP;
  logic [3:0]    SEL_ULA;
  logic [AW-1:0] COMP_ADDR;
  logic [DW-1:0] ULA_RESULT;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .OP_VALID(OP_VALID), .OP_READY(OP_READY),
    .OP_CODE(OP_CODE), .PUSH_DATA(PUSH_DATA), .DONE(DONE),
    .ERR_UNDERFLOW(ERR_UNDERFLOW), .ERR_FULL(ERR_FULL), .TOS(TOS),
    .STACK_ADDR(STACK_ADDR), .STACK_RD_DATA(STACK_RD_DATA),
    .STACK_WR_EN(STACK_WR_EN), .STACK_WR_DATA(STACK_WR_DATA),
    .ALU_OPERAND(ALU_OPERAND), .CTRL_REG_OP1(CTRL_REG_OP1),
    .CTRL_REG_OP2(CTRL_REG_OP2), .CTRL_REG_OVERFLOW(CTRL_REG_OVERFLOW),
    .CTRL_STACK_COMP(CTRL_STACK_COMP), .SEL_ULA(SEL_ULA),
    .COMP_ADDR(COMP_ADDR), .ULA_RESULT(ULA_RESULT)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ALU: IN_2 is the lower operand (REG2), IN_1 the top (REG1)
  function automatic logic [DW-1:0] alu_f(input logic [3:0] s, input logic [DW-1:0] lo,
                                          input logic [DW-1:0] top);
    case (s)
      4'h0: return lo + top;
      4'h1: return lo - top;
      4'h2: return lo & top;
      4'h3: return lo | top;
      4'h4: return lo ^ top;
      4'h8: return ~top;
      default: return '0;
    endcase
  endfunction

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] alu_r1 = '0;
  logic [DW-1:0] alu_r2 = '0;
  int            ovf_cnt = 0;
  int            comp_cnt = 0;
  logic [AW-1:0] comp_addr_seen = '0;
  int            cyc = 0;
  logic          rst_q = 1'b0;

  always @(posedge clk) begin
    STACK_RD_DATA <= mem[STACK_ADDR];
    if (STACK_WR_EN) mem[STACK_ADDR] <= STACK_WR_DATA;
    if (CTRL_REG_OP1) alu_r1 <= ALU_OPERAND;
    if (CTRL_REG_OP2) alu_r2 <= ALU_OPERAND;
    if (CTRL_REG_OVERFLOW) ovf_cnt <= ovf_cnt + 1;
    if (CTRL_STACK_COMP) begin
      comp_cnt       <= comp_cnt + 1;
      comp_addr_seen <= COMP_ADDR;
    end
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  assign ULA_RESULT = alu_f(SEL_ULA, alu_r2, alu_r1);

  // abstract model: stack contents, entry count, sticky flags
  logic [DW-1:0] m_stk [0:7];
  int            m_tos = 0;
  bit            m_uf = 1'b0;
  bit            m_full = 1'b0;

  // expected timeline of the operation in flight
  bit            op_act = 1'b0;
  int            op_c0 = 0;
  int            op_L = 0;
  logic [3:0]    op_code = '0;
  bit            op_err, op_push, op_bin, op_cmp, op_reads, op_wr;
  int            op_old_tos, op_new_tos, op_waddr;
  logic [DW-1:0] op_top, op_low, op_wdata;
  int            last_done_k = 0;

  int  cmp_k, exp_tos;
  bit  e_wr, e_op1, e_op2, e_ovf, e_cmp;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_wr_en", 32'(STACK_WR_EN), 0);
      chk("rst_op_ready", 32'(OP_READY), 0);
      chk("rst_done", 32'(DONE), 0);
      chk("rst_strobes", 32'({CTRL_REG_OP1, CTRL_REG_OP2, CTRL_REG_OVERFLOW, CTRL_STACK_COMP}), 0);
      if (rst_q) begin
        chk("rst_tos", 32'(TOS), 0);
        chk("rst_err", 32'({ERR_UNDERFLOW, ERR_FULL}), 0);
        chk("rst_stack_addr", 32'(STACK_ADDR), 0);
        chk("rst_sel_ula", 32'(SEL_ULA), 0);
        chk("rst_operand", 32'(ALU_OPERAND), 0);
      end
    end else begin
      cmp_k = cyc - op_c0;
      if (op_act && cmp_k >= 1 && cmp_k <= op_L) begin
        exp_tos = (cmp_k < op_L) ? op_old_tos : op_new_tos;
        e_wr  = op_wr && (cmp_k == op_L - 1);
        e_op1 = op_reads && (cmp_k == 2);
        e_op2 = op_reads && (op_bin || op_cmp) && (cmp_k == 3);
        e_ovf = op_reads && op_bin && (cmp_k == 4);
        e_cmp = op_reads && op_cmp && (cmp_k == 4);
        chk("wr_en", 32'(STACK_WR_EN), 32'(e_wr));
        if (e_wr) begin
          chk("wr_addr", 32'(STACK_ADDR), 32'(op_waddr));
          chk("wr_data", 32'(STACK_WR_DATA), 32'(op_wdata));
        end
        if (op_reads && cmp_k == 1) chk("rd_addr_top", 32'(STACK_ADDR), 32'(op_old_tos - 1));
        if (e_op1 && !op_bin && !op_cmp) ;
        else if (e_op1) chk("rd_addr_low", 32'(STACK_ADDR), 32'(op_old_tos - 2));
        chk("op1_strobe", 32'(CTRL_REG_OP1), 32'(e_op1));
        if (e_op1) chk("op1_value", 32'(ALU_OPERAND), 32'(op_top));
        chk("op2_strobe", 32'(CTRL_REG_OP2), 32'(e_op2));
        if (e_op2) chk("op2_value", 32'(ALU_OPERAND), 32'(op_low));
        chk("ovf_strobe", 32'(CTRL_REG_OVERFLOW), 32'(e_ovf));
        chk("comp_strobe", 32'(CTRL_STACK_COMP), 32'(e_cmp));
        chk("comp_addr", 32'(COMP_ADDR), e_cmp ? 32'(op_old_tos - 2) : 32'(exp_tos));
        chk("done", 32'(DONE), 32'(cmp_k == op_L));
        chk("op_ready_busy", 32'(OP_READY), 0);
        chk("tos", 32'(TOS), 32'(exp_tos));
        chk("sel_ula", 32'(SEL_ULA), 32'(op_code));
        chk("err_flags", 32'({ERR_UNDERFLOW, ERR_FULL}), 32'({m_uf, m_full}));
        if (DONE) last_done_k = cmp_k;
      end else begin
        chk("idle_ready", 32'(OP_READY), 1);
        chk("idle_done", 32'(DONE), 0);
        chk("idle_wr_en", 32'(STACK_WR_EN), 0);
        chk("idle_strobes", 32'({CTRL_REG_OP1, CTRL_REG_OP2, CTRL_REG_OVERFLOW, CTRL_STACK_COMP}), 0);
        chk("idle_tos", 32'(TOS), 32'(m_tos));
        chk("idle_comp_addr", 32'(COMP_ADDR), 32'(m_tos));
        chk("idle_err_flags", 32'({ERR_UNDERFLOW, ERR_FULL}), 32'({m_uf, m_full}));
      end
    end
  end

  // Issue one op; returns at negedge+1 of the DONE cycle, or of cycle abort_k if nonzero.
  task automatic do_op(input logic [3:0] code, input logic [DW-1:0] data, input bit hold,
                       input int abort_k);
    bit ok = 1'b0;
    int req;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk); #1;
      if (OP_READY) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    op_code  = code;
    op_push  = (code == 4'hF);
    op_bin   = (code <= 4'h7);
    op_cmp   = (code >= 4'h9 && code <= 4'hE);
    req      = op_push ? 0 : (code == 4'h8) ? 1 : 2;
    op_old_tos = m_tos;
    op_err   = 1'b0;
    op_wr    = 1'b0;
    op_waddr = 0;
    op_wdata = '0;
    op_top   = (m_tos >= 1) ? m_stk[m_tos-1] : '0;
    op_low   = (m_tos >= 2) ? m_stk[m_tos-2] : '0;
    if (m_tos < req) begin
      op_err = 1'b1; m_uf = 1'b1;
    end else if (op_push && m_tos == CAP) begin
      op_err = 1'b1; m_full = 1'b1;
    end else if (op_push) begin
      op_wr = 1'b1; op_waddr = m_tos; op_wdata = data;
      m_stk[m_tos] = data; m_tos++;
    end else if (op_bin) begin
      op_wr = 1'b1; op_waddr = m_tos - 2; op_wdata = alu_f(code, op_low, op_top);
      m_stk[m_tos-2] = op_wdata; m_tos--;
    end else if (op_cmp) begin
      m_tos -= 2;
    end else begin
      op_wr = 1'b1; op_waddr = m_tos - 1; op_wdata = alu_f(code, op_low, op_top);
      m_stk[m_tos-1] = op_wdata;
    end
    op_reads   = !op_err && !op_push;
    op_new_tos = m_tos;
    op_L       = op_err ? 1 : op_push ? 2 : (code == 4'h8) ? 4 : 5;
    OP_VALID   = 1'b1;
    OP_CODE    = code;
    PUSH_DATA  = data;
    op_c0      = cyc;
    op_act     = 1'b1;
    @(negedge clk); #1;
    OP_CODE   = ~code;
    PUSH_DATA = ~data;
    if (!hold) OP_VALID = 1'b0;
    while (cyc < op_c0 + op_L) begin
      if (abort_k != 0 && cyc >= op_c0 + abort_k) break;
      @(negedge clk); #1;
    end
    OP_VALID = 1'b0;
  endtask

  // Caller is at negedge+1; rst spans two rising edges.
  task automatic apply_reset();
    rst    = 1'b1;
    op_act = 1'b0;
    m_tos  = 0;
    m_uf   = 1'b0;
    m_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    OP_VALID  = 1'b0;
    OP_CODE   = '0;
    PUSH_DATA = '0;
    apply_reset();

    // ADD with wrap: 200 + 100 = 44
    do_op(4'hF, 8'd200, 1'b0, 0);
    do_op(4'hF, 8'd100, 1'b0, 0);
    do_op(4'h0, 8'd0, 1'b0, 0);
    chk("add_mem0", 32'(mem[0]), 44);
    chk("add_op1", 32'(alu_r1), 100);
    chk("add_op2", 32'(alu_r2), 200);
    chk("add_tos", 32'(TOS), 1);
    chk("add_latency", 32'(last_done_k), 5);
    chk("add_ovf_count", 32'(ovf_cnt), 1);

    // SUB operand order: lower - top
    do_op(4'hF, 8'd5, 1'b0, 0);
    do_op(4'hF, 8'd3, 1'b0, 0);
    chk("push_latency", 32'(last_done_k), 2);
    do_op(4'h1, 8'd0, 1'b0, 0);
    chk("sub_mem1", 32'(mem[1]), 2);
    chk("sub_tos", 32'(TOS), 2);

    // drain the remaining two with a compare, then EQUAL 7,7 (OP_VALID held high)
    do_op(4'hA, 8'd0, 1'b0, 0);
    chk("cmp_drain_tos", 32'(TOS), 0);
    do_op(4'hF, 8'd7, 1'b0, 0);
    do_op(4'hF, 8'd7, 1'b0, 0);
    do_op(4'h9, 8'd0, 1'b1, 0);
    chk("eq_comp_addr", 32'(comp_addr_seen), 0);
    chk("eq_comp_count", 32'(comp_cnt), 2);
    chk("eq_tos", 32'(TOS), 0);
    chk("eq_latency", 32'(last_done_k), 5);
    chk("eq_ovf_count", 32'(ovf_cnt), 2);

    // NOT, then ADD underflow
    do_op(4'hF, 8'h0F, 1'b0, 0);
    do_op(4'h8, 8'd0, 1'b0, 0);
    chk("not_mem0", 32'(mem[0]), 32'h0F0);
    chk("not_tos", 32'(TOS), 1);
    chk("not_latency", 32'(last_done_k), 4);
    do_op(4'h0, 8'd0, 1'b0, 0);
    chk("uf_flag", 32'(ERR_UNDERFLOW), 1);
    chk("uf_latency", 32'(last_done_k), 1);
    chk("uf_tos", 32'(TOS), 1);
    chk("uf_ovf_count", 32'(ovf_cnt), 2);

    // fill to capacity, then PUSH into a full stack
    do_op(4'hF, 8'd1, 1'b0, 0);
    do_op(4'hF, 8'd2, 1'b0, 0);
    chk("full_tos", 32'(TOS), 3);
    do_op(4'hF, 8'd9, 1'b0, 0);
    chk("full_flag", 32'(ERR_FULL), 1);
    chk("full_no_write", 32'(mem[3]), 0);
    chk("full_tos_kept", 32'(TOS), 3);

    // more binary ops with both sticky flags set
    do_op(4'h2, 8'd0, 1'b0, 0);
    chk("and_mem1", 32'(mem[1]), 0);
    do_op(4'h4, 8'd0, 1'b0, 0);
    chk("xor_mem0", 32'(mem[0]), 32'h0F0);
    chk("sticky_flags", 32'({ERR_UNDERFLOW, ERR_FULL}), 3);

    // reset in the EXEC cycle of an ADD: no write, everything back to reset values
    do_op(4'hF, 8'd100, 1'b0, 0);
    do_op(4'h0, 8'd0, 1'b0, 4);
    apply_reset();
    chk("abort_no_write", 32'(mem[0]), 32'h0F0);
    chk("abort_ovf_count", 32'(ovf_cnt), 4);
    do_op(4'hF, 8'h33, 1'b0, 0);
    chk("post_rst_push", 32'(mem[0]), 32'h33);
    chk("post_rst_tos", 32'(TOS), 1);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
